// File: rtl/vec_imm_buff_pkg.sv
// vec_imm_buff_pkg
// Shared types for the vector immediate buffer loader.
//   byte_t      : one host byte / one vector lane element
//   vib_state_t : loader FSM state (IDLE, LOAD_VEC, LOAD_SCAL)
//   LEN_W       : width of the length byte and of the lane index
package vec_imm_buff_pkg;

    localparam int LEN_W = 8;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_VEC  = 2'd1,
        LOAD_SCAL = 2'd2
    } vib_state_t;

endpackage

// File: rtl/vec_imm_buff_ld.sv
// vec_imm_buff_ld
// Serial-to-parallel immediate buffer. A byte stream from the host builds an
// N-lane, 8-bit vector operand, either element by element (vector load) or by
// replicating one value byte (scalar broadcast). Completion is flagged with a
// one-cycle done pulse. All outputs are registered.
//
// Optional build macro: VEC_IMM_BUFF_ZERO_FILL_EN
//   defined   : lanes L..N-1 are cleared on the edge that accepts a command
//   undefined : lanes L..N-1 keep stale data; consumers must honour out_len
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset
//   in        in   command/data byte
//   set_vec   in   start a vector load (looked at only in IDLE)
//   set_scal  in   start a scalar broadcast (looked at only in IDLE)
//   en        in   byte valid / advance; nothing moves while en=0
//   out       out  N-lane operand, out[i] is lane i
//   out_len   out  active length of the buffered operand
//   done      out  one-cycle pulse on command completion
//   state_dbg out  current FSM state, for observation only
//
// Handshake: there is no back-pressure. A byte on `in` is consumed exactly on
// a rising edge where en=1 and the FSM is in a state that wants a byte.
module vec_imm_buff_ld
    import vec_imm_buff_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  byte_t            in,
    input  logic             set_vec,
    input  logic             set_scal,
    input  logic             en,
    output byte_t            out [N],
    output logic [LEN_W-1:0] out_len,
    output logic             done,
    output vib_state_t       state_dbg
);

    vib_state_t       state, state_next;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] len_in;
    logic             done_next;
    logic             cap_len;
    logic             wr_vec;
    logic             wr_scal;

    // Requested length clamped to the number of lanes.
    always_comb begin
        len_in = in;
        if (in > LEN_W'(N)) len_in = LEN_W'(N);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        cap_len    = 1'b0;
        wr_vec     = 1'b0;
        wr_scal    = 1'b0;
        case (state)
            IDLE: begin
                if (en && (set_vec || set_scal)) begin
                    cap_len = 1'b1;
                    // A zero-length command consumes no data bytes and
                    // completes straight from IDLE.
                    if (len_in == '0) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else if (set_vec) begin
                        state_next = LOAD_VEC;
                    end else begin
                        state_next = LOAD_SCAL;
                    end
                end
            end
            LOAD_VEC: begin
                if (en) begin
                    wr_vec = 1'b1;
                    if (idx == out_len - LEN_W'(1)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            LOAD_SCAL: begin
                if (en) begin
                    wr_scal    = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) out[i] <= '0;
            out_len <= '0;
            idx     <= '0;
            done    <= 1'b0;
        end else begin
            done <= done_next;
            if (cap_len) begin
                out_len <= len_in;
                idx     <= '0;
`ifdef VEC_IMM_BUFF_ZERO_FILL_EN
                for (int i = 0; i < N; i++) begin
                    if (LEN_W'(i) >= len_in) out[i] <= '0;
                end
`endif
            end
            if (wr_vec) begin
                for (int i = 0; i < N; i++) begin
                    if (LEN_W'(i) == idx) out[i] <= in;
                end
                idx <= idx + LEN_W'(1);
            end
            if (wr_scal) begin
                for (int i = 0; i < N; i++) begin
                    if (LEN_W'(i) < out_len) out[i] <= in;
                end
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_vec_imm_buff_ld.sv
module tb_vec_imm_buff_ld;
  import vec_imm_buff_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  byte_t       in;
  logic        set_vec;
  logic        set_scal;
  logic        en;
  byte_t       out [N];
  logic [7:0]  out_len;
  logic        done;
  vib_state_t  state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected lane contents, pushed lane 0 first, drained by check_lanes.
  logic [7:0] exp_q[$];

  vec_imm_buff_ld #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .set_vec   (set_vec),
    .set_scal  (set_scal),
    .en        (en),
    .out       (out),
    .out_len   (out_len),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs, clock one edge, then settle 1ns past the edge for sampling.
  task automatic send(input logic v, input logic s, input logic e, input logic [7:0] b);
    set_vec  = v;
    set_scal = s;
    en       = e;
    in       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                          input logic [7:0] l3, input logic [7:0] l4, input logic [7:0] l5,
                          input logic [7:0] l6, input logic [7:0] l7);
    exp_q.push_back(l0); exp_q.push_back(l1); exp_q.push_back(l2); exp_q.push_back(l3);
    exp_q.push_back(l4); exp_q.push_back(l5); exp_q.push_back(l6); exp_q.push_back(l7);
  endtask

  task automatic check_lanes(input string tag);
    for (int i = 0; i < N; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_lane%0d", tag, i), 32'(out[i]), 32'(e));
    end
  endtask

  initial begin
    // ---------------- reset with garbage stimulus ----------------
    rst = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b1, 1'b1, 1'b1, 8'd5);
    check("rst_done", 32'(done), 32'd0);
    check("rst_len", 32'(out_len), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    push_exp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check_lanes("rst");
    rst = 1'b0;

    // ---------------- vector load, length 4, set_vec wiggled ----------------
    send(1'b1, 1'b0, 1'b1, 8'd4);
    check("vec_len", 32'(out_len), 32'd4);
    check("vec_state", 32'(state_dbg), 32'(LOAD_VEC));
    send(1'b0, 1'b0, 1'b1, 8'h55);
    check("vec_done_b0", 32'(done), 32'd0);
    send(1'b1, 1'b0, 1'b1, 8'h33);
    check("vec_done_b1", 32'(done), 32'd0);
    send(1'b0, 1'b0, 1'b1, 8'hF0);
    check("vec_done_b2", 32'(done), 32'd0);
    send(1'b1, 1'b0, 1'b1, 8'h0F);
    check("vec_done_b3", 32'(done), 32'd1);
    check("vec_state_end", 32'(state_dbg), 32'(IDLE));
    send(1'b0, 1'b0, 1'b0, 8'h00);
    check("vec_done_fall", 32'(done), 32'd0);
    check("vec_len_hold", 32'(out_len), 32'd4);
    push_exp(8'h55, 8'h33, 8'hF0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00);
    check_lanes("vec");

    // ---------------- clamp: length 12 on 8 lanes ----------------
    send(1'b1, 1'b0, 1'b1, 8'd12);
    check("clamp_len", 32'(out_len), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      send(1'b0, 1'b0, 1'b1, 8'(i));
      check($sformatf("clamp_done_b%0d", i), 32'(done), (i == 8) ? 32'd1 : 32'd0);
    end
    // 9th byte lands in IDLE with no set_*: nothing happens.
    send(1'b0, 1'b0, 1'b1, 8'd9);
    check("clamp_done_fall", 32'(done), 32'd0);
    check("clamp_state", 32'(state_dbg), 32'(IDLE));
    check("clamp_len_hold", 32'(out_len), 32'd8);
    push_exp(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    check_lanes("clamp");

    // ---------------- scalar broadcast, length 4 ----------------
    send(1'b0, 1'b1, 1'b1, 8'd4);
    check("scal_len", 32'(out_len), 32'd4);
    check("scal_state", 32'(state_dbg), 32'(LOAD_SCAL));
    check("scal_done_cmd", 32'(done), 32'd0);
    send(1'b0, 1'b0, 1'b1, 8'hF0);
    check("scal_done", 32'(done), 32'd1);
    send(1'b0, 1'b0, 1'b0, 8'h00);
    check("scal_done_fall", 32'(done), 32'd0);
`ifdef VEC_IMM_BUFF_ZERO_FILL_EN
    push_exp(8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
`else
    push_exp(8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'd5, 8'd6, 8'd7, 8'd8);
`endif
    check_lanes("scal");

    // ---------------- stall mid vector load ----------------
    send(1'b1, 1'b0, 1'b1, 8'd3);
    check("stall_len", 32'(out_len), 32'd3);
    send(1'b0, 1'b0, 1'b1, 8'hA1);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b1, 1'b0, 8'hEE);
      check($sformatf("stall_done_%0d", i), 32'(done), 32'd0);
      check($sformatf("stall_state_%0d", i), 32'(state_dbg), 32'(LOAD_VEC));
    end
    check("stall_lane0", 32'(out[0]), 32'hA1);
`ifdef VEC_IMM_BUFF_ZERO_FILL_EN
    check("stall_lane1", 32'(out[1]), 32'hF0);
`else
    check("stall_lane1", 32'(out[1]), 32'hF0);
`endif
    send(1'b0, 1'b0, 1'b1, 8'hA2);
    check("stall_done_b1", 32'(done), 32'd0);
    send(1'b0, 1'b0, 1'b1, 8'hA3);
    check("stall_done_b2", 32'(done), 32'd1);
    send(1'b0, 1'b0, 1'b0, 8'h00);
    check("stall_done_fall", 32'(done), 32'd0);
`ifdef VEC_IMM_BUFF_ZERO_FILL_EN
    push_exp(8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
`else
    push_exp(8'hA1, 8'hA2, 8'hA3, 8'hF0, 8'd5, 8'd6, 8'd7, 8'd8);
`endif
    check_lanes("stall");

    // ---------------- zero length ----------------
    send(1'b1, 1'b0, 1'b1, 8'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_len", 32'(out_len), 32'd0);
    check("zero_state", 32'(state_dbg), 32'(IDLE));
    send(1'b0, 1'b0, 1'b1, 8'h77);
    check("zero_done_fall", 32'(done), 32'd0);
    check("zero_state_idle", 32'(state_dbg), 32'(IDLE));
`ifdef VEC_IMM_BUFF_ZERO_FILL_EN
    push_exp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
`else
    push_exp(8'hA1, 8'hA2, 8'hA3, 8'hF0, 8'd5, 8'd6, 8'd7, 8'd8);
`endif
    check_lanes("zero");

    // ---------------- reset mid load ----------------
    send(1'b1, 1'b0, 1'b1, 8'd4);
    send(1'b0, 1'b0, 1'b1, 8'h11);
    send(1'b0, 1'b0, 1'b1, 8'h22);
    rst = 1'b1;
    send(1'b0, 1'b0, 1'b1, 8'h33);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_len", 32'(out_len), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    push_exp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check_lanes("mid_rst");
    rst = 1'b0;
    send(1'b0, 1'b0, 1'b1, 8'h44);
    check("mid_rst_done_after", 32'(done), 32'd0);

    // ---------------- broadcast then back-to-back vector load ----------------
    send(1'b0, 1'b1, 1'b1, 8'd2);
    check("b2b_scal_len", 32'(out_len), 32'd2);
    send(1'b0, 1'b0, 1'b1, 8'h7C);
    check("b2b_scal_done", 32'(done), 32'd1);
    // New command on the edge right after done rises.
    send(1'b1, 1'b0, 1'b1, 8'd1);
    check("b2b_vec_done_fall", 32'(done), 32'd0);
    check("b2b_vec_len", 32'(out_len), 32'd1);
    check("b2b_vec_state", 32'(state_dbg), 32'(LOAD_VEC));
    send(1'b0, 1'b0, 1'b1, 8'h99);
    check("b2b_vec_done", 32'(done), 32'd1);
    send(1'b0, 1'b0, 1'b0, 8'h00);
    check("b2b_vec_done_fall2", 32'(done), 32'd0);
`ifdef VEC_IMM_BUFF_ZERO_FILL_EN
    push_exp(8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
`else
    push_exp(8'h99, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
`endif
    check_lanes("b2b");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
